// File: rtl/quiz_runner.sv
// quiz_runner: quiz sequencer (load, calc, answer, judge); define QUIZ_TIMEOUT_EN for the per-question countdown
module quiz_runner #(
  parameter int CLK_FREQ   = 100000000,
  parameter int TIME_LIMIT = 10,
  parameter int MAX_Q      = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         mode_sel,
  input  logic               confirm,
  input  logic               select,
  input  logic               exit,
  input  logic [MAX_Q*21-1:0] question_flat,
  input  logic [5:0]         total,
  input  logic [7:0]         answer,
  input  logic [7:0]         calc_result,
  input  logic               calc_valid,
  output logic               calc_req,
  output logic [20:0]        q_data,
  output logic [5:0]         q_index,
  output logic [5:0]         score,
  output logic [4:0]         time_left,
  output logic               judge_valid,
  output logic               last_correct,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, LOAD, CALC, ANSWER, JUDGE, DONE} state_t;
  state_t      state_q, state_d;
  logic [20:0] q_data_q, q_data_d;
  logic [5:0]  q_index_q, q_index_d, score_q, score_d, count;
  logic [4:0]  time_left_q, time_left_d;
  logic [7:0]  expected_q, expected_d;
  logic        last_correct_q, last_correct_d;
  logic        calc_req_q, judge_valid_q, done_q;
  logic        active, expire;
  assign active = mode_sel == 3'b010;
  assign count  = (int'(total) > MAX_Q) ? 6'(MAX_Q) : total;
`ifdef QUIZ_TIMEOUT_EN
  localparam int TW = $clog2(CLK_FREQ + 1);
  logic [TW-1:0] tick_q, tick_d;
  logic          tick;
  assign tick   = tick_q == TW'(CLK_FREQ - 1);
  assign expire = tick && time_left_q <= 5'd1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{CLK_FREQ[0], TIME_LIMIT[0]};
  assign expire = 1'b0;
`endif
  // next-state and datapath: exit/mode leave first, then the per-state rules
  always_comb begin
    state_d        = state_q;
    q_data_d       = q_data_q;
    q_index_d      = q_index_q;
    score_d        = score_q;
    time_left_d    = time_left_q;
    expected_d     = expected_q;
    last_correct_d = last_correct_q;
`ifdef QUIZ_TIMEOUT_EN
    tick_d = (state_q == ANSWER && !tick) ? tick_q + 1'b1 : '0;
`endif
    if (!active || (exit && state_q != IDLE))
      state_d = IDLE;
    else
      case (state_q)
        IDLE: if (confirm) begin
          q_index_d = '0;
          score_d   = '0;
          state_d   = (count == 6'd0) ? DONE : LOAD;
        end
        LOAD: begin
          q_data_d = question_flat[int'(q_index_q)*21 +: 21];
          state_d  = CALC;
        end
        CALC: if (calc_valid) begin
          expected_d = calc_result;
`ifdef QUIZ_TIMEOUT_EN
          time_left_d = 5'(TIME_LIMIT);
`else
          time_left_d = 5'd0;
`endif
          state_d = ANSWER;
        end
        ANSWER: begin
`ifdef QUIZ_TIMEOUT_EN
          if (tick && time_left_q != 5'd0) time_left_d = time_left_q - 5'd1;
`endif
          if (confirm || select || expire) begin
            last_correct_d = confirm && answer == expected_q;
            score_d        = (last_correct_d && int'(score_q) < MAX_Q) ? score_q + 6'd1 : score_q;
            q_index_d      = q_index_q + 6'd1;
            state_d        = JUDGE;
          end
        end
        JUDGE: state_d = (q_index_q == count) ? DONE : LOAD;
        DONE: if (confirm) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  // state and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      q_data_q       <= '0;
      q_index_q      <= '0;
      score_q        <= '0;
      time_left_q    <= '0;
      expected_q     <= '0;
      last_correct_q <= 1'b0;
      calc_req_q     <= 1'b0;
      judge_valid_q  <= 1'b0;
      done_q         <= 1'b0;
`ifdef QUIZ_TIMEOUT_EN
      tick_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      q_data_q       <= q_data_d;
      q_index_q      <= q_index_d;
      score_q        <= score_d;
      time_left_q    <= time_left_d;
      expected_q     <= expected_d;
      last_correct_q <= last_correct_d;
      calc_req_q     <= state_d == CALC;
      judge_valid_q  <= state_d == JUDGE;
      done_q         <= state_d == DONE;
`ifdef QUIZ_TIMEOUT_EN
      tick_q         <= tick_d;
`endif
    end
  end
  assign calc_req     = calc_req_q;
  assign q_data       = q_data_q;
  assign q_index      = q_index_q;
  assign score        = score_q;
  assign time_left    = time_left_q;
  assign judge_valid  = judge_valid_q;
  assign last_correct = last_correct_q;
  assign done         = done_q;
endmodule

// File: tb/tb_quiz_runner.sv
// tb_quiz_runner: randomized quiz games, scoreboard of expected judgements checked by a monitor
module tb_quiz_runner;
  localparam int MQ = 50, CF = 4, TL = 2;
`ifdef QUIZ_TIMEOUT_EN
  localparam int NA = 6, TL_EXP = TL;
`else
  localparam int NA = 5, TL_EXP = 0;
`endif
  logic clk = 1'b0, reset, confirm, select, ex, calc_valid;
  logic [2:0] mode_sel;
  logic [MQ*21-1:0] question_flat;
  logic [5:0] total, q_index, score;
  logic [7:0] answer, calc_result;
  logic calc_req, judge_valid, last_correct, done;
  logic [20:0] q_data;
  logic [4:0] time_left;
  typedef struct {int c; int sc; int qi;} exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, njudge = 0;

  quiz_runner #(.CLK_FREQ(CF), .TIME_LIMIT(TL), .MAX_Q(MQ)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel), .confirm(confirm), .select(select),
    .exit(ex), .question_flat(question_flat), .total(total), .answer(answer),
    .calc_result(calc_result), .calc_valid(calc_valid), .calc_req(calc_req),
    .q_data(q_data), .q_index(q_index), .score(score), .time_left(time_left),
    .judge_valid(judge_valid), .last_correct(last_correct), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // the external calculator as the bench plays it
  function automatic logic [7:0] calc(input logic [20:0] e);
    logic [7:0] a, b;
    a = e[15:8];
    b = e[7:0];
    case (e[17:16])
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return 8'(a * b);
      default: return a ^ b;
    endcase
  endfunction

  task automatic wait_calc();
    for (int k = 0; k < 8 && !calc_req; k++) step();
    chk("calc_req_rise", calc_req, 1);
  endtask

  // act: 0 confirm ok, 1 confirm wrong, 2 select, 3 both wrong, 4 both ok, 5 timeout; <0 random
  // ab: question at whose CALC the game is abandoned via kind 0 exit, 1 mode_sel, 2 reset
  task automatic run_game(input int n, input int act, input int ab, input int kind);
    int cnt, sc, d, hi, a, j0, c;
    logic [20:0] ent;
    logic [7:0] r;
    logic [4:0] tl_prev;
    cnt = n > MQ ? MQ : n;
    total = 6'(n);
    for (int i = 0; i < MQ; i++) question_flat[i*21 +: 21] = 21'($urandom);
    j0 = njudge;
    sc = 0;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      wait_calc();
      ent = question_flat[i*21 +: 21];
      chk("q_data", int'(q_data), int'(ent));
      chk("q_index", q_index, i);
      chk("score_before", score, sc);
      if (i == ab) begin
        if (kind == 0) begin
          ex = 1'b1;
          step();
          ex = 1'b0;
          chk("exit_calc_req", calc_req, 0);
          chk("exit_score", score, sc);
          repeat (3) step();
          chk("exit_stays_idle", calc_req, 0);
        end else if (kind == 1) begin
          mode_sel = 3'b001;
          step();
          chk("mode_calc_req", calc_req, 0);
          chk("mode_score", score, sc);
          chk("mode_q_index", q_index, i);
          confirm = 1'b1;
          step();
          confirm = 1'b0;
          repeat (2) step();
          chk("mode_inactive", calc_req, 0);
          mode_sel = 3'b010;
        end else begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          chk("rst_calc_req", calc_req, 0);
          chk("rst_score", score, 0);
          chk("rst_q_index", q_index, 0);
          chk("rst_q_data", int'(q_data), 0);
          chk("rst_time_left", time_left, 0);
          repeat (2) step();
        end
        return;
      end
      tl_prev = time_left;
      d = $urandom_range(1, 6);
      hi = 0;
      r = calc(ent);
      for (int k = 1; k <= d; k++) begin
        hi += int'(calc_req);
        if (time_left != tl_prev) chk("time_left_calc", time_left, tl_prev);
        if (k == d) begin
          calc_valid = 1'b1;
          calc_result = r;
        end
        step();
      end
      calc_valid = 1'b0;
      chk("calc_req_cycles", hi, d);
      chk("calc_req_drop", calc_req, 0);
      chk("time_left_load", time_left, TL_EXP);
      a = act < 0 ? int'($urandom_range(0, NA - 1)) : act;
      c = (a == 0 || a == 4) ? 1 : 0;
      if (a != 5)
        repeat ($urandom_range(0, 2)) begin
          calc_valid = 1'b1;
          calc_result = 8'($urandom);
          step();
        end
      calc_valid = 1'b0;
      sc = (sc + c > MQ) ? MQ : sc + c;
      exp_q.push_back('{c, sc, i + 1});
      if (a == 5) begin
        repeat (TL * CF - 1) step();
        chk("timeout_early", judge_valid, 0);
        step();
        chk("timeout_judge", judge_valid, 1);
        chk("timeout_time_left", time_left, 0);
      end else begin
        answer = (c == 1 || a == 2) ? r : r ^ 8'($urandom_range(1, 255));
        confirm = a != 2;
        select = a >= 2;
        step();
        confirm = 1'b0;
        select = 1'b0;
        chk("judge_pulse", judge_valid, 1);
      end
    end
    if (cnt > 0) step();
    chk("done", done, 1);
    chk("done_q_index", q_index, cnt);
    chk("done_score", score, sc);
    chk("judge_count", njudge - j0, cnt);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    chk("done_exit", done, 0);
  endtask

  // monitor: every judge_valid pulse must match the oldest outstanding expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (judge_valid) begin
      njudge++;
      if (exp_q.size() == 0) chk("unexpected_judge", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("last_correct", last_correct, e.c);
        chk("judge_score", score, e.sc);
        chk("judge_q_index", q_index, e.qi);
      end
    end
  end

  initial begin
    reset = 1'b1;
    mode_sel = 3'b010;
    {confirm, select, ex, calc_valid} = '0;
    total = '0;
    answer = '0;
    calc_result = '0;
    question_flat = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_calc_req", calc_req, 0);
    chk("rst_q_data", int'(q_data), 0);
    chk("rst_q_index", q_index, 0);
    chk("rst_score", score, 0);
    chk("rst_time_left", time_left, 0);
    chk("rst_judge_valid", judge_valid, 0);
    chk("rst_last_correct", last_correct, 0);
    chk("rst_done", done, 0);
    run_game(0, 0, -1, 0);
    run_game(3, 0, -1, 0);
    run_game(2, 3, -1, 0);
    run_game(2, 4, -1, 0);
    run_game(3, 1, -1, 0);
    run_game(3, 2, -1, 0);
    run_game(8, -1, -1, 0);
    run_game(4, 0, 2, 0);
    run_game(3, -1, 1, 1);
    run_game(3, 0, 1, 2);
`ifdef QUIZ_TIMEOUT_EN
    run_game(2, 5, -1, 0);
`endif
    run_game(60, -1, -1, 0);
    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quiz_runner.md
QUIZ_RUNNER -- requirements
Module: quiz_runner

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, sets clock cycles per one-second countdown tick.
REQ-002 Parameter TIME_LIMIT, default 10, sets seconds allowed per question (range 1..31).
REQ-003 Parameter MAX_Q, default 50, sets question-store depth.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode_sel  input  3  block active only when equal to 3'b010.
REQ-007 confirm, select, exit  input  1 each  single-cycle debounced button pulses.
REQ-008 question_flat  input  1050  MAX_Q 21-bit entries; entry i at bits [i*21 +: 21]; fields [20:18] mode, [17:16] op, [15:8] a, [7:0] b.
REQ-009 total  input  6  number of stored questions.
REQ-010 answer  input  8  player answer from switches.
REQ-011 calc_result  input  8  expected result from external calculator.
REQ-012 calc_valid  input  1  calc_result valid.
REQ-013 calc_req  output  1  request calculation of q_data.
REQ-014 q_data  output  21  current question entry.
REQ-015 q_index  output  6  current question index, 0-based.
REQ-016 score  output  6  correct-answer count.
REQ-017 time_left  output  5  seconds remaining on current question.
REQ-018 judge_valid  output  1  one-cycle pulse when a question is judged.
REQ-019 last_correct  output  1  outcome of most recent judgement.
REQ-020 done  output  1  high in DONE state.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, CALC, ANSWER, JUDGE, DONE.
REQ-022 mode_sel != 3'b010 SHALL force IDLE next cycle; calc_req low; score and q_index held.
REQ-023 Effective count SHALL be min(total, MAX_Q).
REQ-024 IDLE + confirm: count 0 -> DONE; else q_index=0, score=0 -> LOAD.
REQ-025 LOAD SHALL latch q_data = entry[q_index] in one cycle, then go CALC.
REQ-026 CALC: calc_req high; hold until calc_valid sampled high, capture calc_result as expected, drop calc_req same edge, reload time_left=TIME_LIMIT, go ANSWER.
REQ-027 ANSWER: confirm -> JUDGE, correct = (answer == expected); select -> JUDGE, correct=0 (skip).
REQ-028 JUDGE (one cycle): judge_valid=1, last_correct=correct, score+1 if correct (saturate at MAX_Q); q_index+1; if new q_index == count -> DONE, else LOAD.
REQ-029 DONE: done=1, q_index=count, score held; confirm -> IDLE.
REQ-030 exit in any state except IDLE SHALL go IDLE next cycle; score held.
REQ-031 Priority: exit > confirm > select > timeout.
REQ-032 calc_valid outside CALC SHALL be ignored.
REQ-033 Question latency: LOAD 1 cycle + CALC >=1 cycle before ANSWER.

Reset
REQ-034 Reset SHALL set state IDLE, q_data=0, q_index=0, score=0, time_left=0, calc_req=0, judge_valid=0, last_correct=0, done=0, expected=0, tick counter=0.
REQ-035 Reset mid-question SHALL abandon it; no judge_valid pulse.

Configuration
REQ-036 With QUIZ_TIMEOUT_EN defined: in ANSWER a tick counter counts CLK_FREQ cycles, time_left decrements per tick; on reaching 0 without confirm/select -> JUDGE with correct=0; confirm on the expiring cycle wins.
REQ-037 Without QUIZ_TIMEOUT_EN: no tick counter, time_left constant 0, ANSWER waits indefinitely.

Verification
REQ-038 total=3, entries answered correctly (answer==calc_result each) -> three judge_valid pulses, last_correct=1 each, score=3, done=1, q_index=3.
REQ-039 total=0, confirm in IDLE -> DONE next cycle, score=0.
REQ-040 In ANSWER, confirm and select same cycle with answer!=expected -> last_correct=0, score unchanged; repeat with match -> score+1.
REQ-041 QUIZ_TIMEOUT_EN, CLK_FREQ=4, TIME_LIMIT=2, no input -> judge_valid exactly 8 cycles after ANSWER entry, last_correct=0.
REQ-042 calc_valid delayed 5 cycles -> calc_req high 5 cycles, time_left unchanged until ANSWER; exit during CALC -> IDLE, calc_req low.
REQ-043 total=60 -> exactly 50 questions judged, done=1, q_index=50.
